dm_store_packer: RTL
====================

// Module: dm_store_packer
// PURPOSE
// Store-side counterpart of the load/immediate extenders: narrows a 32-bit register value to
// word/half/byte (sw/sh/sb) and writes it into word-organised data memory with no byte enables.
// Partial stores use a read-modify-write sequence driven by an FSM. Sits between the MEM stage
// and DM; the core stalls while req_ready=0.
// PARAMETERS
// ADDR_W      10  word-address width driven on mem_addr (DM depth = 2**ADDR_W words)
// RD_LATENCY  1   DM read latency in cycles, legal 1..4
// PORTS
// clk         in   1       single clock, rising edge
// reset       in   1       asynchronous, active-high
// req_valid   in   1       store request present
// req_ready   out  1       1 only in IDLE; request accepted when req_valid&&req_ready
// req_addr    in   32      byte address
// req_data    in   32      register value to store
// req_type    in   2       00 sw, 01 sh, 10 sb, 11 reserved
// done        out  1       one-cycle pulse when the request retires
// err         out  1       misalignment/reserved-type flag, valid with done (0 unless ALIGN_CHECK_EN)
// mem_addr    out  ADDR_W  word address = latched req_addr[ADDR_W+1:2]
// mem_re      out  1       DM read strobe
// mem_rdata   in   32      DM read data, valid RD_LATENCY cycles after the mem_re cycle
// mem_we      out  1       DM write strobe
// mem_wdata   out  32      DM write data
// BEHAVIOUR
// - States: IDLE, READ, WAIT, WRITE, DONE. Accept in IDLE latches addr/data/type.
// - IDLE->WRITE for sw; IDLE->READ for sh/sb; IDLE->DONE for type 11 (no DM access).
// - READ: mem_re=1 for exactly one cycle, cnt<=1 -> WAIT.
// - WAIT: if cnt==RD_LATENCY capture mem_rdata into merge reg -> WRITE; else cnt<=cnt+1.
// - WRITE: mem_we=1 for exactly one cycle with merged word -> DONE.
// - DONE: done=1 (err per config) for one cycle -> IDLE. No new request accepted in DONE.
// - Merge (little-endian lanes): sw full word; sh addr[1]=0 -> [15:0]<=data[15:0],
//   addr[1]=1 -> [31:16]<=data[15:0]; sb lane k=addr[1:0] -> [8k+7:8k]<=data[7:0]; rest from DM.
// - Latency from accept cycle T: sw WRITE at T+1, done at T+2; sh/sb WRITE at T+2+RD_LATENCY,
//   done at T+3+RD_LATENCY.
// - mem_addr/mem_wdata registered; hold last value outside WRITE/READ; mem_re/mem_we 0 elsewhere.
// - Reset (any time, incl. mid-sequence): state IDLE, cnt 0, mem_re=mem_we=0, mem_addr=0,
//   mem_wdata=0, done=0, err=0, req_ready=1 once reset deasserts. In-flight store discarded,
//   no partial write ever issued after reset asserts.
// - req_valid while busy is ignored (not queued); requester must hold it until req_ready.
// - Address above DM range: upper bits silently dropped (wrap-around within 2**ADDR_W words).
// CONFIGURATION
// ALIGN_CHECK_EN defined: sw with addr[1:0]!=0, sh with addr[0]!=0, or type 11 -> IDLE->DONE,
//   no DM access, err=1 together with done. Otherwise err=0.
// ALIGN_CHECK_EN undefined: low address bits ignored (sw uses word addr, sh uses addr[1] only),
//   type 11 retires with no write, err tied 0.
// TESTING
// 1 sw addr=0x0000_0008 data=0xDEADBEEF -> mem_we at T+1, mem_addr=2, mem_wdata=0xDEADBEEF, done T+2.
// 2 DM[1]=0x11223344; sb addr=0x6 data=0xAB -> mem_re T+1, mem_wdata=0x11AB3344 at T+3, done T+4.
// 3 DM[1]=0x11223344; sh addr=0x6 data=0x0000CAFE -> mem_wdata=0xCAFE3344; addr=0x4 -> 0x1122CAFE.
// 4 RD_LATENCY=3, sb addr=0x3 data=0x55, DM[0]=0 -> WRITE at T+5, mem_wdata=0x55000000, done T+6.
// 5 Assert reset during WAIT of an sb -> mem_re/mem_we stay 0, no write, req_ready=1 after release.
// 6 sh addr=0x5: with ALIGN_CHECK_EN -> done+err at T+1, no mem_re/mem_we; without -> normal RMW
//   writing lower half of word 1.

Source files
------------

// File: rtl/dm_store_packer_if.sv
// Store request / data-memory bus between the MEM stage, dm_store_packer and word-organised DM.
// slave = packer side, master = core + memory side.
interface dm_store_packer_if #(
    parameter int unsigned ADDR_W = 10
);
    logic              req_valid;
    logic              req_ready;
    logic [31:0]       req_addr;
    logic [31:0]       req_data;
    logic [1:0]        req_type;
    logic              done;
    logic              err;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_re;
    logic [31:0]       mem_rdata;
    logic              mem_we;
    logic [31:0]       mem_wdata;

    modport slave (
        input  req_valid, req_addr, req_data, req_type, mem_rdata,
        output req_ready, done, err, mem_addr, mem_re, mem_we, mem_wdata
    );

    modport master (
        output req_valid, req_addr, req_data, req_type, mem_rdata,
        input  req_ready, done, err, mem_addr, mem_re, mem_we, mem_wdata
    );
endinterface

// File: rtl/dm_store_packer.sv
// sw/sh/sb store packer: full-word writes directly, partial stores via read-modify-write of DM.
// Optional macro ALIGN_CHECK_EN: reject misaligned/reserved stores with err instead of ignoring low bits.
module dm_store_packer #(
    parameter int unsigned ADDR_W     = 10,
    parameter int unsigned RD_LATENCY = 1
) (
    input logic              clk,
    input logic              reset,
    dm_store_packer_if.slave bus
);
    localparam int unsigned CNT_W = 3;
    localparam logic [1:0]  T_SW  = 2'b00;
    localparam logic [1:0]  T_SH  = 2'b01;
    localparam logic [1:0]  T_SB  = 2'b10;
    localparam logic [1:0]  T_RSV = 2'b11;

    typedef enum logic [2:0] {
        S_IDLE,
        S_READ,
        S_WAIT,
        S_WRITE,
        S_DONE
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic [15:0]      data_q;
    logic [1:0]       type_q;
    logic [1:0]       lane_q;

    logic             err_c;
    logic             skip_c;
    logic [31:0]      merged_c;

    // A rejected or reserved request retires straight from IDLE without touching DM.
`ifdef ALIGN_CHECK_EN
    assign err_c = (bus.req_type == T_SW && bus.req_addr[1:0] != 2'b00) ||
                   (bus.req_type == T_SH && bus.req_addr[0]) ||
                   (bus.req_type == T_RSV);
`else
    assign err_c = 1'b0;
`endif
    assign skip_c = err_c || (bus.req_type == T_RSV);

    // Little-endian lane merge of the latched store data into the word read back from DM.
    always_comb begin
        merged_c = bus.mem_rdata;
        case (type_q)
            T_SH: begin
                if (lane_q[1]) merged_c[31:16] = data_q;
                else           merged_c[15:0]  = data_q;
            end
            T_SB:    merged_c[{lane_q, 3'b000} +: 8] = data_q[7:0];
            default: merged_c = bus.mem_rdata;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state         <= S_IDLE;
            cnt           <= '0;
            data_q        <= '0;
            type_q        <= '0;
            lane_q        <= '0;
            bus.req_ready <= 1'b1;
            bus.done      <= 1'b0;
            bus.err       <= 1'b0;
            bus.mem_re    <= 1'b0;
            bus.mem_we    <= 1'b0;
            bus.mem_addr  <= '0;
            bus.mem_wdata <= '0;
        end else begin
            bus.done   <= 1'b0;
            bus.err    <= 1'b0;
            bus.mem_re <= 1'b0;
            bus.mem_we <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (bus.req_valid && bus.req_ready) begin
                        bus.req_ready <= 1'b0;
                        data_q        <= bus.req_data[15:0];
                        type_q        <= bus.req_type;
                        lane_q        <= bus.req_addr[1:0];
                        if (skip_c) begin
                            state    <= S_DONE;
                            bus.done <= 1'b1;
                            bus.err  <= err_c;
                        end else if (bus.req_type == T_SW) begin
                            state         <= S_WRITE;
                            bus.mem_we    <= 1'b1;
                            bus.mem_addr  <= bus.req_addr[ADDR_W+1:2];
                            bus.mem_wdata <= bus.req_data;
                        end else begin
                            state        <= S_READ;
                            bus.mem_re   <= 1'b1;
                            bus.mem_addr <= bus.req_addr[ADDR_W+1:2];
                        end
                    end
                end
                S_READ: begin
                    cnt   <= CNT_W'(1);
                    state <= S_WAIT;
                end
                S_WAIT: begin
                    if (cnt == CNT_W'(RD_LATENCY)) begin
                        state         <= S_WRITE;
                        bus.mem_we    <= 1'b1;
                        bus.mem_wdata <= merged_c;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                S_WRITE: begin
                    state    <= S_DONE;
                    bus.done <= 1'b1;
                end
                S_DONE: begin
                    state         <= S_IDLE;
                    cnt           <= '0;
                    bus.req_ready <= 1'b1;
                end
                default: begin
                    state         <= S_IDLE;
                    bus.req_ready <= 1'b1;
                end
            endcase
        end
    end
endmodule
